bp_be_issue_queue: RTL and testbench

- Parametrised replayable issue buffer between the FE queue interface and BE dispatch. It brings the clear, roll and dequeue control that previously acted on the FE-side queue inside the BE.
- Holds fetch packets, presents the oldest un-issued packet to the scheduler, and keeps issued-but-uncommitted packets for replay.
- Three pointers: write, issue (read) and commit. Supports flush (clr), replay-from-commit (roll) and in-order commit (deq).

---
 rtl/bp_be_issue_queue.sv | 71 +++++++
 tb/tb_bp_be_issue_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: replayable issue buffer with write, issue and commit pointers
//   clk_i, reset_n_i              clock, async active-low reset
//   fe_pkt_i, fe_v_i, fe_ready_o  enqueue side (ready-valid)
//   iss_pkt_o, iss_v_o, iss_yumi_i issue side (oldest un-issued packet)
//   clr_i, roll_i, deq_i          flush, replay from commit, in-order commit
//   unissued_cnt_o, uncommitted_cnt_o, empty_o, full_o  occupancy status
//   Optional same-cycle enqueue-to-issue bypass: BP_BE_ISSUE_QUEUE_BYPASS_EN
module bp_be_issue_queue #(
    parameter int els_p = 16,
    parameter int pkt_width_p = 128,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [pkt_width_p-1:0]  fe_pkt_i,
    input  logic                    fe_v_i,
    output logic                    fe_ready_o,
    output logic [pkt_width_p-1:0]  iss_pkt_o,
    output logic                    iss_v_o,
    input  logic                    iss_yumi_i,
    input  logic                    clr_i,
    input  logic                    roll_i,
    input  logic                    deq_i,
    output logic [ptr_width_lp-1:0] unissued_cnt_o,
    output logic [ptr_width_lp-1:0] uncommitted_cnt_o,
    output logic                    empty_o,
    output logic                    full_o
);
    localparam int lg_els_lp = $clog2(els_p);
    logic [pkt_width_p-1:0]  mem [els_p];
    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_n;
    logic enq, adv, deq_ok;
    assign unissued_cnt_o    = wptr - rptr;
    assign uncommitted_cnt_o = rptr - cptr;
    assign empty_o           = wptr == cptr;
    assign full_o            = (wptr - cptr) == ptr_width_lp'(els_p);
    assign fe_ready_o        = ~full_o;
    assign enq               = fe_v_i & fe_ready_o & ~clr_i;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
    logic byp;
    // Empty issue window: hand the incoming packet straight to the scheduler
    assign byp       = (wptr == rptr) & fe_v_i & fe_ready_o & ~clr_i & ~roll_i;
    assign iss_v_o   = (rptr != wptr) | byp;
    assign iss_pkt_o = byp ? fe_pkt_i : mem[rptr[lg_els_lp-1:0]];
`else
    assign iss_v_o   = rptr != wptr;
    assign iss_pkt_o = mem[rptr[lg_els_lp-1:0]];
`endif
    assign adv    = iss_yumi_i & iss_v_o & ~clr_i & ~roll_i;
    assign deq_ok = deq_i & (rptr != cptr);
    // Commit lands first so clr/roll rewind to the post-commit pointer
    assign cptr_n = cptr + ptr_width_lp'(deq_ok);
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            cptr <= cptr_n;
            wptr <= clr_i ? cptr_n : wptr + ptr_width_lp'(enq);
            rptr <= (clr_i | roll_i) ? cptr_n : rptr + ptr_width_lp'(adv);
        end
    end
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr[lg_els_lp-1:0]] <= fe_pkt_i;
    end
`ifndef SYNTHESIS
    a_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(iss_yumi_i & ~iss_v_o));
    a_deq:  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(deq_i & (rptr == cptr)));
`endif
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb_bp_be_issue_queue: directed and randomized checks against a packet-queue reference model
module tb_bp_be_issue_queue;
    localparam int N = 16;
    localparam int W = 128;
    localparam int PW = $clog2(N) + 1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [W-1:0] fe_pkt, iss_pkt;
    logic fe_v, fe_ready, iss_v, yumi, clr, roll, deq, empty, full;
    logic [PW-1:0] unissued, uncommitted;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];
    int nc = 0;
    logic [W-1:0] seen;

    bp_be_issue_queue #(.els_p(N), .pkt_width_p(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .fe_pkt_i(fe_pkt), .fe_v_i(fe_v), .fe_ready_o(fe_ready),
        .iss_pkt_o(iss_pkt), .iss_v_o(iss_v), .iss_yumi_i(yumi),
        .clr_i(clr), .roll_i(roll), .deq_i(deq),
        .unissued_cnt_o(unissued), .uncommitted_cnt_o(uncommitted),
        .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic rchk(input string tag);
        chk({tag, "_iss_v"}, W'(iss_v), W'(0));
        chk({tag, "_empty"}, W'(empty), W'(1));
        chk({tag, "_full"}, W'(full), W'(0));
        chk({tag, "_ready"}, W'(fe_ready), W'(1));
        chk({tag, "_unissued"}, W'(unissued), W'(0));
        chk({tag, "_uncommitted"}, W'(uncommitted), W'(0));
    endtask

    // Model: q holds every packet from the commit point onward; the first nc are issued
    task automatic step(input logic v, input logic [W-1:0] p, input logic y, input logic c,
                        input logic r, input logic d);
        logic byp, ev, rdy;
        logic [W-1:0] ep;
        fe_v = v; fe_pkt = p; yumi = y; clr = c; roll = r; deq = d;
        #1;
        rdy = q.size() < N;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        byp = (q.size() == nc) && v && rdy && !c && !r;
`else
        byp = 1'b0;
`endif
        ev = (q.size() > nc) || byp;
        ep = byp ? p : ((q.size() > nc) ? q[nc] : '0);
        seen = iss_pkt;
        chk("iss_v", W'(iss_v), W'(ev));
        if (ev) chk("iss_pkt", iss_pkt, ep);
        chk("unissued", W'(unissued), W'(q.size() - nc));
        chk("uncommitted", W'(uncommitted), W'(nc));
        chk("empty", W'(empty), W'(q.size() == 0));
        chk("full", W'(full), W'(q.size() == N));
        chk("ready", W'(fe_ready), W'(rdy));
        @(posedge clk);
        if (d && nc > 0) begin
            void'(q.pop_front());
            nc--;
        end
        if (c) begin
            q.delete();
            nc = 0;
        end else begin
            if (r) nc = 0;
            else if (y && ev) nc++;
            if (v && rdy) q.push_back(p);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b, c, dd;
        int sent, got;
        fe_v = 0; fe_pkt = '0; yumi = 0; clr = 0; roll = 0; deq = 0;
        repeat (2) @(negedge clk);
        rchk("reset");
        reset_n = 1'b1;
        @(negedge clk);
        idle();
        // Reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        fe_v = 0; yumi = 0; clr = 0; roll = 0; deq = 0;
        #2 reset_n = 1'b0;
        #1 rchk("async_reset");
        q.delete();
        nc = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        // Fill to full, drop the 17th, then free one slot
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, W'(17), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        // Roll after committing the first of four issued packets
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        dd = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, dd, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("roll_pkt_b", seen, b);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Clear together with deq and an enqueue
        step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, dd, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        // Wrap-around stream with random stalls
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
            logic v, y, d, acc;
            v = (sent < 40) && ($urandom_range(0, 3) != 0);
            acc = v && (q.size() < N);
            y = (q.size() > nc) && ($urandom_range(0, 2) == 0);
            d = (nc > 0) && ($urandom_range(0, 2) == 0);
            step(v, W'(sent), y, 1'b0, 1'b0, d);
            if (acc) sent++;
            if (y) begin
                chk("wrap_seq", seen, W'(got));
                got++;
            end
        end
        chk("wrap_done", W'(got), W'(40));
        for (int i = 0; i < 40 && nc > 0; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        // Same-cycle enqueue/issue on an empty queue
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        step(1'b1, W'(16'hABCD), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bypass_pkt", seen, W'(16'hABCD));
`else
        step(1'b1, W'(16'hABCD), 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
